// File: rtl/rfphoenix_mt_insn_fifo_if.sv
// Bus bundle for the multi-thread instruction queue: push side, pop/read
// side, per-channel flush and the status/error outputs.
interface rfphoenix_mt_insn_fifo_if #(
    parameter int WID = 128,
    parameter int DEP = 16,
    parameter int NCH = 4
);
    localparam int CW = $clog2(DEP) + 1;
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    logic              wr;
    logic [SW-1:0]     wr_ch;
    logic [WID-1:0]    din;
    logic              rd;
    logic [SW-1:0]     rd_ch;
    logic [WID-1:0]    dout;
    logic              v;
    logic [NCH-1:0]    flush;
    logic [NCH*CW-1:0] cnt;
    logic [NCH-1:0]    empty;
    logic [NCH-1:0]    full;
    logic [NCH-1:0]    almost_full;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr, wr_ch, din, rd, rd_ch, flush,
        input  dout, v, cnt, empty, full, almost_full, overflow, underflow
    );

    modport slave (
        input  wr, wr_ch, din, rd, rd_ch, flush,
        output dout, v, cnt, empty, full, almost_full, overflow, underflow
    );
endinterface

// File: rtl/rfphoenix_mt_insn_fifo.sv
// Per-thread instruction queue sitting between fetch/decode and issue.
// NCH independent first-word-fall-through FIFOs of DEP x WID entries kept in
// distributed RAM, with per-channel flush, occupancy counts, a programmable
// almost-full threshold and one-cycle overflow/underflow error pulses.
module rfphoenix_mt_insn_fifo #(
    parameter int WID   = 128,
    parameter int DEP   = 16,
    parameter int NCH   = 4,
    parameter int AFULL = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    rfphoenix_mt_insn_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEP);
    localparam int CW = AW + 1;
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    // Storage and per-channel bookkeeping.
    logic [WID-1:0]    mem     [NCH][DEP];
    logic [AW-1:0]     wptr_q  [NCH];
    logic [AW-1:0]     rptr_q  [NCH];
    logic [CW-1:0]     cnt_q   [NCH];
    logic              overflow_q;
    logic              underflow_q;

    // Decoded status and per-channel handshake qualification.
    logic [NCH-1:0]    empty_d;
    logic [NCH-1:0]    full_d;
    logic [NCH-1:0]    afull_d;
    logic [NCH-1:0]    wr_sel;
    logic [NCH-1:0]    rd_sel;
    logic [NCH-1:0]    push_ok;
    logic [NCH-1:0]    pop_ok;
    logic [NCH-1:0]    push_rej;
    logic [NCH-1:0]    pop_rej;

    logic [WID-1:0]    dout_d;
    logic              v_d;
    logic [NCH*CW-1:0] cnt_flat;

    // Status flags come straight from the registered occupancy of each channel.
    always_comb begin
        empty_d = '0;
        full_d  = '0;
        afull_d = '0;
        for (int i = 0; i < NCH; i++) begin
            empty_d[i] = (cnt_q[i] == '0);
            full_d[i]  = (cnt_q[i] == CW'(DEP));
            afull_d[i] = (cnt_q[i] >= CW'(AFULL));
        end
    end

    // Qualify push/pop per channel; channel selects beyond NCH-1 match nothing
    // and so are silently ignored, and a flushed channel neither accepts nor errors.
    always_comb begin
        wr_sel   = '0;
        rd_sel   = '0;
        push_ok  = '0;
        pop_ok   = '0;
        push_rej = '0;
        pop_rej  = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_sel[i]   = bus.wr && (bus.wr_ch == SW'(i));
            rd_sel[i]   = bus.rd && (bus.rd_ch == SW'(i));
            push_ok[i]  = wr_sel[i] && !full_d[i]  && !bus.flush[i];
            pop_ok[i]   = rd_sel[i] && !empty_d[i] && !bus.flush[i];
            push_rej[i] = wr_sel[i] &&  full_d[i]  && !bus.flush[i];
            pop_rej[i]  = rd_sel[i] &&  empty_d[i] && !bus.flush[i];
        end
    end

    // Pointer/count update per channel: flush wins over traffic, and a
    // simultaneous accepted push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.flush[i]) begin
                    wptr_q[i] <= '0;
                    rptr_q[i] <= '0;
                    cnt_q[i]  <= '0;
                end else begin
                    if (push_ok[i]) begin
                        wptr_q[i] <= wptr_q[i] + AW'(1);
                    end
                    if (pop_ok[i]) begin
                        rptr_q[i] <= rptr_q[i] + AW'(1);
                    end
                    cnt_q[i] <= cnt_q[i] + CW'(push_ok[i]) - CW'(pop_ok[i]);
                end
            end
            overflow_q  <= |push_rej;
            underflow_q <= |pop_rej;
        end
    end

    // RAM write port; contents are never cleared, only the pointers are.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (!rst && push_ok[i]) begin
                mem[i][wptr_q[i]] <= bus.din;
            end
        end
    end

    // Fall-through read of the selected channel's head; zero when it is empty
    // or when the channel select points past the last channel.
    always_comb begin
        dout_d = '0;
        v_d    = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if ((bus.rd_ch == SW'(i)) && !empty_d[i]) begin
                dout_d = mem[i][rptr_q[i]];
                v_d    = 1'b1;
            end
        end
    end

    // Pack the per-channel counts into the flat status bus.
    always_comb begin
        cnt_flat = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_flat[i*CW +: CW] = cnt_q[i];
        end
    end

    assign bus.dout        = dout_d;
    assign bus.v           = v_d;
    assign bus.cnt         = cnt_flat;
    assign bus.empty       = empty_d;
    assign bus.full        = full_d;
    assign bus.almost_full = afull_d;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
endmodule
